axil_ram_slave: RTL

AXI4-Lite slave that fronts a single-port, word-addressed block RAM on the PL side. It responds to an AXI4-Lite master such as the processing system or the AXI VIP master agent. Write address and write data channels are captured independently, with one outstanding write and one outstanding read. A round-robin arbiter shares the single RAM port between the read and write paths. The block sits behind the AXI interconnect and is the responder counterpart of the master-side traffic generators in the lab designs.

---
 rtl/axil_ram_pkg.sv | 29 ++
 rtl/axil_ram_bram.sv | 32 +++
 rtl/axil_ram_slave.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/axil_ram_pkg.sv
// Shared types, response codes and address helper for the AXI4-Lite RAM slave.
package axil_ram_pkg;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_MEM  = 2'd1,
        W_RESP = 2'd2
    } wr_state_t;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_MEM  = 2'd1,
        R_DATA = 2'd2
    } rd_state_t;

    typedef enum logic {
        GRANT_READ  = 1'b0,
        GRANT_WRITE = 1'b1
    } grant_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Byte address to 32-bit word index; the two lane-select bits are dropped.
    function automatic logic [31:0] word_index(input logic [31:0] byteAddr);
        return byteAddr >> 2;
    endfunction

endpackage

// File: rtl/axil_ram_bram.sv
// Single-port RAM with per-byte write enables and a registered read port.
module axil_ram_bram #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
) (
    input  logic                  i_clk,
    input  logic [ADDR_W-1:0]     i_addr,
    input  logic [DATA_W/8-1:0]   i_be,
    input  logic [DATA_W-1:0]     i_wdata,
    input  logic                  i_rdEn,
    output logic [DATA_W-1:0]     o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    // Contents are deliberately not reset so the array maps onto block RAM.
    always_ff @(posedge i_clk) begin
        for (int b = 0; b < DATA_W / 8; b++) begin
            if (i_be[b]) begin
                r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
            end
        end
        if (i_rdEn) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/axil_ram_slave.sv
// AXI4-Lite slave in front of a word-addressed RAM, read/write paths share one port.
// Define AXIL_RAM_SLAVE_ADDR_CHECK_EN to reject out-of-range accesses with SLVERR.
module axil_ram_slave
    import axil_ram_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 6,
    parameter int C_RAM_DEPTH        = 16
) (
    input  logic                              ACLK,
    input  logic                              ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic [2:0]                        S_AXI_AWPROT,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,
    output logic [1:0]                        S_AXI_BRESP,
    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic [2:0]                        S_AXI_ARPROT,
    input  logic                              S_AXI_ARVALID,
    output logic                              S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                        S_AXI_RRESP,
    output logic                              S_AXI_RVALID,
    input  logic                              S_AXI_RREADY
);

    localparam int IDX_W  = (C_RAM_DEPTH > 1) ? $clog2(C_RAM_DEPTH) : 1;
    localparam int STRB_W = C_S_AXI_DATA_WIDTH / 8;

    wr_state_t                      r_wrState;
    rd_state_t                      r_rdState;
    grant_t                         r_lastGrant;
    logic                           r_awHeld, r_wHeld;
    logic [C_S_AXI_ADDR_WIDTH-1:0]  r_awAddr, r_arAddr;
    logic [C_S_AXI_DATA_WIDTH-1:0]  r_wData, r_rData;
    logic [STRB_W-1:0]              r_wStrb;
    logic                           r_awReady, r_wReady, r_arReady, r_bValid, r_rValid;
    logic [1:0]                     r_bResp, r_rResp;

    logic [31:0]                    w_wrIdx, w_rdIdx;
    logic                           w_wrInRange, w_rdInRange;
    logic                           w_awHs, w_wHs, w_awHave, w_wHave;
    logic                           w_wrReq, w_rdReq, w_grantWr, w_grantRd;
    logic [IDX_W-1:0]               w_ramAddr;
    logic [STRB_W-1:0]              w_ramBe;
    logic [C_S_AXI_DATA_WIDTH-1:0]  w_ramQ;
    logic                           w_unused;

    assign w_wrIdx = word_index(32'(r_awAddr));
    assign w_rdIdx = word_index(32'(r_arAddr));

`ifdef AXIL_RAM_SLAVE_ADDR_CHECK_EN
    assign w_wrInRange = (w_wrIdx < 32'(C_RAM_DEPTH));
    assign w_rdInRange = (w_rdIdx < 32'(C_RAM_DEPTH));
`else
    // Without checking, the low index bits alone select the word, so accesses alias.
    assign w_wrInRange = 1'b1;
    assign w_rdInRange = 1'b1;
`endif

    assign w_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, w_wrIdx, w_rdIdx};

    assign w_awHs   = r_awReady & S_AXI_AWVALID;
    assign w_wHs    = r_wReady & S_AXI_WVALID;
    assign w_awHave = r_awHeld | w_awHs;
    assign w_wHave  = r_wHeld | w_wHs;
    assign w_wrReq  = (r_wrState == W_MEM);
    assign w_rdReq  = (r_rdState == R_MEM);

    // On a collision the path that did not win last time gets the port.
    always_comb begin
        w_grantWr = 1'b0;
        w_grantRd = 1'b0;
        if (w_wrReq && w_rdReq) begin
            if (r_lastGrant == GRANT_READ) w_grantWr = 1'b1;
            else                           w_grantRd = 1'b1;
        end else begin
            w_grantWr = w_wrReq;
            w_grantRd = w_rdReq;
        end
    end

    assign w_ramAddr = w_grantWr ? w_wrIdx[IDX_W-1:0] : w_rdIdx[IDX_W-1:0];
    assign w_ramBe   = (w_grantWr && w_wrInRange) ? r_wStrb : '0;

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET)         r_lastGrant <= GRANT_READ;
        else if (w_grantWr) r_lastGrant <= GRANT_WRITE;
        else if (w_grantRd) r_lastGrant <= GRANT_READ;
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_wrState <= W_IDLE;
            r_awHeld  <= 1'b0;
            r_wHeld   <= 1'b0;
            r_awAddr  <= '0;
            r_wData   <= '0;
            r_wStrb   <= '0;
            r_awReady <= 1'b0;
            r_wReady  <= 1'b0;
            r_bValid  <= 1'b0;
            r_bResp   <= RESP_OKAY;
        end else begin
            case (r_wrState)
                W_IDLE: begin
                    if (w_awHs) begin
                        r_awAddr <= S_AXI_AWADDR;
                        r_awHeld <= 1'b1;
                    end
                    if (w_wHs) begin
                        r_wData <= S_AXI_WDATA;
                        r_wStrb <= S_AXI_WSTRB;
                        r_wHeld <= 1'b1;
                    end
                    if (w_awHave && w_wHave) begin
                        r_wrState <= W_MEM;
                        r_awReady <= 1'b0;
                        r_wReady  <= 1'b0;
                    end else begin
                        r_awReady <= !w_awHave;
                        r_wReady  <= !w_wHave;
                    end
                end
                W_MEM: begin
                    if (w_grantWr) begin
                        r_wrState <= W_RESP;
                        r_awHeld  <= 1'b0;
                        r_wHeld   <= 1'b0;
                        r_bResp   <= w_wrInRange ? RESP_OKAY : RESP_SLVERR;
                    end
                end
                W_RESP: begin
                    if (!r_bValid) begin
                        r_bValid <= 1'b1;
                    end else if (S_AXI_BREADY) begin
                        r_bValid  <= 1'b0;
                        r_wrState <= W_IDLE;
                        r_awReady <= 1'b1;
                        r_wReady  <= 1'b1;
                    end
                end
                default: r_wrState <= W_IDLE;
            endcase
        end
    end

    // RDATA is captured from the RAM output register one cycle after the port grant.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_rdState <= R_IDLE;
            r_arAddr  <= '0;
            r_arReady <= 1'b0;
            r_rValid  <= 1'b0;
            r_rData   <= '0;
            r_rResp   <= RESP_OKAY;
        end else begin
            case (r_rdState)
                R_IDLE: begin
                    if (r_arReady && S_AXI_ARVALID) begin
                        r_arAddr  <= S_AXI_ARADDR;
                        r_arReady <= 1'b0;
                        r_rdState <= R_MEM;
                    end else begin
                        r_arReady <= 1'b1;
                    end
                end
                R_MEM: begin
                    if (w_grantRd) r_rdState <= R_DATA;
                end
                R_DATA: begin
                    if (!r_rValid) begin
                        r_rValid <= 1'b1;
                        r_rData  <= w_rdInRange ? w_ramQ : '0;
                        r_rResp  <= w_rdInRange ? RESP_OKAY : RESP_SLVERR;
                    end else if (S_AXI_RREADY) begin
                        r_rValid  <= 1'b0;
                        r_rdState <= R_IDLE;
                        r_arReady <= 1'b1;
                    end
                end
                default: r_rdState <= R_IDLE;
            endcase
        end
    end

    axil_ram_bram #(
        .DEPTH  (C_RAM_DEPTH),
        .ADDR_W (IDX_W),
        .DATA_W (C_S_AXI_DATA_WIDTH)
    ) u_bram (
        .i_clk   (ACLK),
        .i_addr  (w_ramAddr),
        .i_be    (w_ramBe),
        .i_wdata (r_wData),
        .i_rdEn  (w_grantRd),
        .o_rdata (w_ramQ)
    );

    assign S_AXI_AWREADY = r_awReady;
    assign S_AXI_WREADY  = r_wReady;
    assign S_AXI_BVALID  = r_bValid;
    assign S_AXI_BRESP   = r_bResp;
    assign S_AXI_ARREADY = r_arReady;
    assign S_AXI_RVALID  = r_rValid;
    assign S_AXI_RDATA   = r_rData;
    assign S_AXI_RRESP   = r_rResp;

endmodule
